// File: rtl/red_pitaya_asg_ch.sv
// red_pitaya_asg_ch: one ASG channel with waveform table, phase pointer, burst FSM and scaled/saturated DAC output
module red_pitaya_asg_ch #(
  parameter int DW        = 14,
  parameter int RSZ       = 14,
  parameter int CYC_US    = 125,
  parameter int INTERP_EN = 1
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rstn_i,
  input  logic                  buf_we_i,
  input  logic [RSZ-1:0]        buf_addr_i,
  input  logic [DW-1:0]         buf_wdata_i,
  output logic [DW-1:0]         buf_rdata_o,
  input  logic [RSZ+15:0]       set_size_i,
  input  logic [RSZ+15:0]       set_step_i,
  input  logic [RSZ+15:0]       set_ofs_i,
  input  logic [DW-1:0]         set_amp_i,
  input  logic [DW-1:0]         set_dc_i,
  input  logic [15:0]           set_ncyc_i,
  input  logic [15:0]           set_rnum_i,
  input  logic [31:0]           set_rdly_i,
  input  logic [2:0]            set_src_i,
  input  logic                  set_wrap_i,
  input  logic                  set_rst_i,
  input  logic                  set_zero_i,
  input  logic                  set_interp_i,
  input  logic                  trig_sw_i,
  input  logic                  trig_ext_i,
  output logic signed [DW-1:0]  dac_o,
  output logic [RSZ-1:0]        rd_ptr_o,
  output logic                  run_o,
  output logic                  busy_o,
  output logic                  trig_o,
  output logic                  done_o
);
  localparam int PW  = RSZ + 16;
  localparam int DLW = 32 + $clog2(CYC_US + 1);
  localparam logic signed [DW+2:0] SMAX = (DW+3)'(2**(DW-1) - 1);
  localparam logic signed [DW+2:0] SMIN = -(DW+3)'(2**(DW-1));
  typedef enum logic [1:0] {IDLE, RUN, DLY} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ofs_ld, ptr_run;
  logic [15:0] cyc_q, cyc_d, bst_q, bst_d, bst_inc;
  logic [DLW-1:0] dly_q, dly_d, dly_lim;
  logic ext_q, trig_q, trig_d, done_q, done_d;
  logic [PW:0] nxt, per;
  logic bnd, trig_hit, burst_end, last_burst;
  logic signed [DW-1:0] mem [2**RSZ];
  logic signed [DW-1:0] s0_q, s1_q, y_q, y_d, dac_q, dac_d;
  logic [DW-1:0] rdata_q;
  logic [7:0] fr_q;
  logic [RSZ-1:0] idx, idx1;
  logic signed [DW:0] diff;
  logic signed [DW+9:0] prod;
  logic signed [2*DW:0] gp;
  logic signed [DW+1:0] g_q, g_d;
  logic signed [DW+2:0] sum;
  assign nxt        = {1'b0, ptr_q} + {1'b0, set_step_i};
  assign per        = {1'b0, set_size_i} + (PW+1)'(1);
  assign bnd        = nxt > {1'b0, set_size_i};
  assign ofs_ld     = (set_ofs_i > set_size_i) ? '0 : set_ofs_i;
  assign ptr_run    = bnd ? (set_wrap_i ? PW'(nxt - per) : '0) : nxt[PW-1:0];
  assign trig_hit   = (set_src_i == 3'd1) ? trig_sw_i :
                      (set_src_i == 3'd2) ? (trig_ext_i & ~ext_q) :
                      (set_src_i == 3'd3) ? (~trig_ext_i & ext_q) : (set_src_i == 3'd4);
  assign burst_end  = (state_q == RUN) && bnd && (set_ncyc_i != 16'd0) && (cyc_q + 16'd1 >= set_ncyc_i);
  assign bst_inc    = bst_q + 16'd1;
  assign last_burst = (set_rnum_i != 16'd0) && (bst_inc >= set_rnum_i);
  assign dly_lim    = DLW'(set_rdly_i) * DLW'(CYC_US);
  always_comb begin
    state_d = state_q;
    ptr_d   = ofs_ld;
    cyc_d   = cyc_q;
    bst_d   = bst_q;
    dly_d   = '0;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    if (set_rst_i) begin
      state_d = IDLE;
      cyc_d   = '0;
      bst_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (trig_hit) begin
          state_d = RUN;
          trig_d  = 1'b1;
          cyc_d   = '0;
          bst_d   = '0;
        end
        RUN: if (burst_end) begin
          cyc_d   = '0;
          bst_d   = last_burst ? '0 : bst_inc;
          done_d  = last_burst;
          state_d = last_burst ? IDLE : (set_rdly_i == 32'd0) ? RUN : DLY;
        end else begin
          ptr_d = ptr_run;
          cyc_d = bnd ? cyc_q + 16'd1 : cyc_q;
        end
        DLY: if (dly_q + DLW'(1) >= dly_lim) state_d = RUN;
             else dly_d = dly_q + DLW'(1);
        default: state_d = IDLE;
      endcase
    end
  end
  // idx+1 neighbour for interpolation; at the last index it wraps or repeats
  assign idx  = ptr_q[PW-1:16];
  assign idx1 = (idx == set_size_i[PW-1:16]) ? (set_wrap_i ? '0 : idx) : idx + RSZ'(1);
  assign diff = $signed({s1_q[DW-1], s1_q}) - $signed({s0_q[DW-1], s0_q});
  assign prod = diff * $signed({1'b0, fr_q});
  assign y_d  = (INTERP_EN != 0 && set_interp_i) ? DW'(s0_q + (prod >>> 8)) : s0_q;
  assign gp   = y_q * $signed({1'b0, set_amp_i});
  assign g_d  = (DW+2)'(gp >>> (DW-1));
  assign sum  = g_q + $signed(set_dc_i);
  assign dac_d = set_zero_i ? '0 : (sum > SMAX) ? SMAX[DW-1:0] : (sum < SMIN) ? SMIN[DW-1:0] : sum[DW-1:0];
  always_ff @(posedge dac_clk_i)
    if (buf_we_i) mem[buf_addr_i] <= buf_wdata_i;
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cyc_q   <= '0;
      bst_q   <= '0;
      dly_q   <= '0;
      ext_q   <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      fr_q    <= '0;
      y_q     <= '0;
      g_q     <= '0;
      dac_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      bst_q   <= bst_d;
      dly_q   <= dly_d;
      ext_q   <= trig_ext_i;
      trig_q  <= trig_d;
      done_q  <= done_d;
      rdata_q <= mem[buf_addr_i];
      s0_q    <= mem[idx];
      s1_q    <= mem[idx1];
      fr_q    <= ptr_q[15:8];
      y_q     <= y_d;
      g_q     <= g_d;
      dac_q   <= dac_d;
    end
  end
  assign buf_rdata_o = rdata_q;
  assign dac_o       = dac_q;
  assign rd_ptr_o    = ptr_q[PW-1:16];
  assign run_o       = state_q == RUN;
  assign busy_o      = state_q != IDLE;
  assign trig_o      = trig_q;
  assign done_o      = done_q;
endmodule

// File: tb/tb_red_pitaya_asg_ch.sv
// tb_red_pitaya_asg_ch: directed checks of table, timing, interpolation, scaling, burst FSM and resets
module tb_red_pitaya_asg_ch;
  localparam int DW = 14, RSZ = 14;
  logic clk = 1'b0, rstn = 1'b0;
  logic we = 1'b0;
  logic [RSZ-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [RSZ+15:0] size = '0, stp = '0, ofs = '0;
  logic [DW-1:0] amp = '0, dc = '0;
  logic [15:0] ncyc = '0, rnum = '0;
  logic [31:0] rdly = '0;
  logic [2:0] src = '0;
  logic wrap = 1'b0, srst = 1'b0, zero = 1'b0, interp = 1'b0, tsw = 1'b0, text = 1'b0;
  logic signed [DW-1:0] dac;
  logic [RSZ-1:0] rptr;
  logic run, busy, trig, done;
  int npass = 0, nchk = 0, nfail = 0;
  int t3 [9] = '{0, 64, 128, 192, 256, 192, 128, 64, 0};
  int nrun, ndly, ndone, nwin, done_at;
  logic prev;

  always #5 clk = ~clk;

  red_pitaya_asg_ch dut (
    .dac_clk_i(clk), .dac_rstn_i(rstn), .buf_we_i(we), .buf_addr_i(addr), .buf_wdata_i(wdata),
    .buf_rdata_o(rdata), .set_size_i(size), .set_step_i(stp), .set_ofs_i(ofs), .set_amp_i(amp),
    .set_dc_i(dc), .set_ncyc_i(ncyc), .set_rnum_i(rnum), .set_rdly_i(rdly), .set_src_i(src),
    .set_wrap_i(wrap), .set_rst_i(srst), .set_zero_i(zero), .set_interp_i(interp),
    .trig_sw_i(tsw), .trig_ext_i(text), .dac_o(dac), .rd_ptr_o(rptr), .run_o(run),
    .busy_o(busy), .trig_o(trig), .done_o(done)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1; addr = RSZ'(a); wdata = DW'(d);
    tick(1);
    we = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_dac", dac, 0); chk("rst_run", run, 0); chk("rst_busy", busy, 0);
    chk("rst_trig", trig, 0); chk("rst_done", done, 0); chk("rst_ptr", rptr, 0); chk("rst_rdata", rdata, 0);
    rstn = 1'b1;
    // 1: ramp table, free-run
    srst = 1'b1; size = {14'd7, 16'hffff}; stp = 30'h10000; amp = 14'h2000; dc = '0; src = 3'd4; wrap = 1'b1;
    for (int i = 0; i < 8; i++) wr(i, i);
    addr = 14'd5; tick(1);
    chk("t1_rdback", rdata, 5);
    srst = 1'b0; tick(1);
    chk("t1_trig", trig, 1); chk("t1_run", run, 1); chk("t1_busy", busy, 1); chk("t1_ptr0", rptr, 0);
    tick(1);
    chk("t1_trig_pulse", trig, 0); chk("t1_ptr1", rptr, 1);
    tick(3);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_dac%0d", k), dac, k % 8);
      tick(1);
    end
    // 2: gain, offset, saturation, zero
    srst = 1'b1; src = 3'd0; tick(1);
    wr(0, 8000); amp = 14'h3fff; dc = 14'd500; tick(6);
    chk("t2_satpos", dac, 8191);
    amp = 14'h2000; dc = 14'd100; tick(4);
    chk("t2_lin", dac, 8100);
    wr(0, -8000); dc = DW'(-500); tick(6);
    chk("t2_satneg", dac, -8192);
    zero = 1'b1; tick(1);
    chk("t2_zero", dac, 0);
    zero = 1'b0; tick(1);
    chk("t2_unzero", dac, -8192);
    // 3: interpolation with wrap
    wr(0, 0); wr(1, 256);
    size = {14'd1, 16'hffff}; stp = 30'h4000; interp = 1'b1; dc = '0; ofs = '0; src = 3'd1;
    srst = 1'b0; tick(2);
    chk("t3_idle", run, 0);
    tsw = 1'b1; tick(1); tsw = 1'b0;
    chk("t3_trig", trig, 1);
    tick(4);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t3_dac%0d", k), dac, t3[k]);
      tick(1);
    end
    tsw = 1'b1; tick(1); tsw = 1'b0;
    chk("t3_trig_in_run", trig, 0); chk("t3_still_run", run, 1);
    // 5: set_rst beats a simultaneous trigger
    ofs = 30'h14000; srst = 1'b1; tsw = 1'b1; tick(1);
    chk("t5_run", run, 0); chk("t5_busy", busy, 0); chk("t5_trig", trig, 0); chk("t5_ptr", rptr, 1);
    srst = 1'b0; tsw = 1'b0; tick(2);
    chk("t5_idle", run, 0);
    // 4: bursts with repetition delay, external rising edge
    srst = 1'b1; interp = 1'b0; ofs = '0; size = {14'd3, 16'hffff}; stp = 30'h10000;
    ncyc = 16'd2; rnum = 16'd3; rdly = 32'd1; src = 3'd2; text = 1'b0;
    tick(2); srst = 1'b0; tick(2);
    chk("t4_idle", busy, 0);
    text = 1'b1; tick(1);
    chk("t4_trig", trig, 1); chk("t4_run", run, 1);
    nrun = 0; ndly = 0; ndone = 0; nwin = 0; done_at = -1; prev = 1'b0;
    for (int i = 0; i < 320; i++) begin
      nrun += int'(run);
      ndly += int'(busy && !run);
      if (done) begin ndone++; done_at = i; end
      if (run && !prev) nwin++;
      prev = run;
      tick(1);
    end
    chk("t4_run_cycles", nrun, 24); chk("t4_dly_cycles", ndly, 250); chk("t4_windows", nwin, 3);
    chk("t4_done_cnt", ndone, 1); chk("t4_done_at", done_at, 274); chk("t4_end_idle", busy, 0);
    text = 1'b0; tick(2);
    text = 1'b1; tick(1);
    chk("t4_retrig", trig, 1); chk("t4_rerun", run, 1);
    // 6: async reset mid-burst
    tick(5);
    chk("t6_busy_pre", busy, 1);
    src = 3'd0; #2 rstn = 1'b0; #1;
    chk("t6_dac", dac, 0); chk("t6_run", run, 0); chk("t6_busy", busy, 0); chk("t6_ptr", rptr, 0);
    tick(1);
    rstn = 1'b1; addr = 14'd1; tick(1);
    chk("t6_rd1", rdata, 256);
    addr = 14'd6; tick(1);
    chk("t6_rd6", rdata, 6); chk("t6_idle", run, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
